// File: rtl/xcel_pkg.sv
// Shared types and AXI constants for the OFM writeback engine.
package xcel_pkg;

  typedef enum logic [2:0] {IDLE, AW, W, B, DONE} wb_state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int WB_FIFO_DEPTH = 4;

endpackage

// File: rtl/xcel_ofm_writeback_if.sv
// AXI4 write channels (AW, W, B) between the writeback engine and the memory fabric.
interface xcel_ofm_writeback_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready
  );
endinterface

// File: rtl/xcel_wb_fifo.sv
// 4-deep, 32-bit synchronous prefetch FIFO with show-ahead head word.
module xcel_wb_fifo
  import xcel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty,
  output logic [2:0]  count
);

  logic [31:0] mem_q [WB_FIFO_DEPTH];
  logic [31:0] mem_d [WB_FIFO_DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        do_push, do_pop;

  assign full    = (cnt_q == 3'(WB_FIFO_DEPTH));
  assign empty   = (cnt_q == 3'd0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 2'd1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/xcel_ofm_writeback.sv
// Streams OFM words from BRAM to DDR as AXI4 INCR write bursts via a 4-deep prefetch FIFO.
// Optional: define XCEL_WB_RELU_EN to zero negative words on the write data path.
module xcel_ofm_writeback
  import xcel_pkg::*;
#(
  parameter int OFM_AWIDTH = 13,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  idle,
  output logic                  done,
  output logic                  err,
  input  logic [31:0]           ofm_ddr_addr,
  input  logic [31:0]           ofm_len,
  output logic [OFM_AWIDTH-1:0] ofm_addr,
  input  logic [31:0]           ofm_dout,
  xcel_ofm_writeback_if.master  axi
);

  wb_state_e   state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] len_q, len_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] issued_q, issued_d;
  logic [8:0]  beats_q, beats_d;
  logic [8:0]  beat_cnt_q, beat_cnt_d;
  logic        err_q, err_d;
  logic        inflight_q, inflight_d;

  logic [31:0] remaining;
  logic [8:0]  cur_beats;
  logic        rd_en, w_fire;
  logic [31:0] fifo_dout;
  logic        fifo_full, fifo_empty;
  logic [2:0]  fifo_count;

  assign remaining = len_q - issued_q;
  assign cur_beats = (remaining < 32'(BURST_LEN)) ? remaining[8:0] : 9'(BURST_LEN);

  // Reads in flight are counted so a late BRAM word always has a FIFO slot.
  assign rd_en  = (state_q != IDLE) && (rd_cnt_q < len_q) &&
                  ((fifo_count + {2'b00, inflight_q}) < 3'(WB_FIFO_DEPTH));
  assign w_fire = axi.wvalid && axi.wready;

  xcel_wb_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (ofm_dout),
    .pop   (w_fire),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign idle     = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign ofm_addr = rd_cnt_q[OFM_AWIDTH-1:0];

  assign axi.awvalid = (state_q == AW);
  assign axi.awaddr  = base_q + (issued_q << 2);
  assign axi.awlen   = 8'(cur_beats - 9'd1);
  assign axi.awsize  = AXI_SIZE_4B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wvalid  = (state_q == W) && !fifo_empty;
  assign axi.wstrb   = 4'hF;
  assign axi.wlast   = (state_q == W) && (beat_cnt_q == beats_q - 9'd1);
  assign axi.bready  = (state_q == B);

`ifdef XCEL_WB_RELU_EN
  assign axi.wdata = fifo_dout[31] ? 32'h0 : fifo_dout;
`else
  assign axi.wdata = fifo_dout;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    rd_cnt_d   = rd_en ? rd_cnt_q + 32'd1 : rd_cnt_q;
    issued_d   = issued_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    inflight_d = rd_en;
    case (state_q)
      IDLE: if (start) begin
        base_d   = ofm_ddr_addr & ~32'h3F;
        len_d    = ofm_len;
        rd_cnt_d = '0;
        issued_d = '0;
        err_d    = 1'b0;
        state_d  = (ofm_len == 32'd0) ? DONE : AW;
      end
      AW: if (axi.awready) begin
        beats_d    = cur_beats;
        beat_cnt_d = '0;
        issued_d   = issued_q + 32'(cur_beats);
        state_d    = W;
      end
      W: if (w_fire) begin
        beat_cnt_d = beat_cnt_q + 9'd1;
        if (axi.wlast) state_d = B;
      end
      B: if (axi.bvalid) begin
        if (axi.bresp != AXI_RESP_OKAY) err_d = 1'b1;
        state_d = (issued_q < len_q) ? AW : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      issued_q   <= issued_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_xcel_ofm_writeback.sv
// Directed bench for xcel_ofm_writeback: BRAM model, AXI write slave with optional random stalls.
module tb_xcel_ofm_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        idle, done, err;
  logic [31:0] ofm_ddr_addr = '0;
  logic [31:0] ofm_len = '0;
  logic [12:0] ofm_addr;
  logic [31:0] ofm_dout = '0;

  xcel_ofm_writeback_if axi();

  xcel_ofm_writeback #(.OFM_AWIDTH(13), .BURST_LEN(16)) dut (
    .clk(clk), .rst(rst), .start(start), .idle(idle), .done(done), .err(err),
    .ofm_ddr_addr(ofm_ddr_addr), .ofm_len(ofm_len), .ofm_addr(ofm_addr),
    .ofm_dout(ofm_dout), .axi(axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] img(int i);
    logic [31:0] v;
    if (i == 0) return 32'hFFFF_FF80;
    v = 32'(i) * 32'h9E37_79B1 + 32'h0000_1234;
    return v;
  endfunction

  function automatic logic [31:0] exp_word(int i);
    logic [31:0] v;
    v = img(i);
`ifdef XCEL_WB_RELU_EN
    if (v[31]) v = 32'h0;
`endif
    return v;
  endfunction

  logic [31:0] bram [0:8191];
  initial for (int i = 0; i < 8192; i++) bram[i] = img(i);
  always @(posedge clk) ofm_dout <= bram[ofm_addr];

  // AXI slave: ready/valid updated shortly after each edge
  bit rand_mode = 0;
  int err_burst = 0;
  int aw_cnt = 0, aw_tgt = 0, b_cnt_dly = 0, b_tgt = 0;
  int b_cnt = 0, done_cnt = 0;
  logic err_at_done = 1'b0;

  initial begin
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
  end

  always @(posedge clk) begin
    #2;
    axi.wready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (axi.awvalid) begin
      if (aw_cnt >= aw_tgt) axi.awready = 1'b1;
      else begin axi.awready = 1'b0; aw_cnt++; end
    end else begin
      axi.awready = 1'b0;
      aw_cnt = 0;
      aw_tgt = rand_mode ? int'($urandom_range(0, 7)) : 0;
    end
    if (axi.bready) begin
      if (b_cnt_dly >= b_tgt) begin
        axi.bvalid = 1'b1;
        axi.bresp  = (b_cnt + 1 == err_burst) ? 2'b10 : 2'b00;
      end else begin axi.bvalid = 1'b0; b_cnt_dly++; end
    end else begin
      axi.bvalid = 1'b0;
      axi.bresp  = 2'b00;
      b_cnt_dly  = 0;
      b_tgt      = rand_mode ? int'($urandom_range(0, 7)) : 0;
    end
  end

  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q [$];
  logic [2:0]  aw_size_q [$];
  logic [1:0]  aw_burst_q [$];
  logic [31:0] w_data_q [$];
  logic        w_last_q [$];
  logic [3:0]  w_strb_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (axi.awvalid && axi.awready) begin
        aw_addr_q.push_back(axi.awaddr);
        aw_len_q.push_back(axi.awlen);
        aw_size_q.push_back(axi.awsize);
        aw_burst_q.push_back(axi.awburst);
      end
      if (axi.wvalid && axi.wready) begin
        w_data_q.push_back(axi.wdata);
        w_last_q.push_back(axi.wlast);
        w_strb_q.push_back(axi.wstrb);
      end
      if (axi.bvalid && axi.bready) b_cnt++;
      if (done) begin done_cnt++; err_at_done = err; end
    end
  end

  task automatic mon_clear();
    aw_addr_q.delete(); aw_len_q.delete(); aw_size_q.delete(); aw_burst_q.delete();
    w_data_q.delete(); w_last_q.delete(); w_strb_q.delete();
    b_cnt = 0; done_cnt = 0; err_at_done = 1'b0;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] l);
    @(negedge clk);
    ofm_ddr_addr = a; ofm_len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    @(negedge clk);
  endtask

  function automatic int data_errs(int n);
    int e = 0;
    for (int i = 0; i < n && i < w_data_q.size(); i++)
      if (w_data_q[i] !== exp_word(i)) e++;
    return e;
  endfunction

  function automatic int last_errs(int n, int bl);
    int e = 0;
    for (int i = 0; i < w_last_q.size(); i++)
      if (w_last_q[i] !== ((i % bl == bl - 1) || (i == n - 1))) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (axi.awvalid !== 1'b0) begin failures++; $display("FAIL reset_awvalid got=%b exp=0", axi.awvalid); end
    checks++; if (axi.wvalid !== 1'b0) begin failures++; $display("FAIL reset_wvalid got=%b exp=0", axi.wvalid); end
    checks++; if (axi.bready !== 1'b0) begin failures++; $display("FAIL reset_bready got=%b exp=0", axi.bready); end
    checks++; if (ofm_addr !== 13'd0) begin failures++; $display("FAIL reset_ofm_addr got=%0d exp=0", ofm_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    bit seen;
    mon_clear();
    launch(32'h0000_1000, 32'd0);
    seen = done;
    @(negedge clk);
    seen = seen | done;
    repeat (4) @(negedge clk);
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL zero_done_latency got=%b exp=1", seen); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (aw_addr_q.size() !== 0) begin failures++; $display("FAIL zero_aw_count got=%0d exp=0", aw_addr_q.size()); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL zero_idle got=%b exp=1", idle); end
  endtask

  task automatic test_two_bursts();
    bit ok;
    int se;
    mon_clear();
    launch(32'h2000_0047, 32'd20);
    wait_done(2000, ok);
    se = 0;
    foreach (w_strb_q[i]) if (w_strb_q[i] !== 4'hF) se++;
    checks++; if (!ok) begin failures++; $display("FAIL two_timeout got=0 exp=1"); end
    checks++; if (aw_addr_q.size() !== 2) begin failures++; $display("FAIL two_aw_count got=%0d exp=2", aw_addr_q.size()); end
    checks++; if ((aw_addr_q.size() > 0 ? aw_addr_q[0] : 'x) !== 32'h2000_0040) begin failures++; $display("FAIL two_awaddr0 got=%h exp=20000040", aw_addr_q.size() > 0 ? aw_addr_q[0] : 'x); end
    checks++; if ((aw_addr_q.size() > 1 ? aw_addr_q[1] : 'x) !== 32'h2000_0080) begin failures++; $display("FAIL two_awaddr1 got=%h exp=20000080", aw_addr_q.size() > 1 ? aw_addr_q[1] : 'x); end
    checks++; if ((aw_len_q.size() > 0 ? aw_len_q[0] : 'x) !== 8'd15) begin failures++; $display("FAIL two_awlen0 got=%0d exp=15", aw_len_q.size() > 0 ? aw_len_q[0] : 'x); end
    checks++; if ((aw_len_q.size() > 1 ? aw_len_q[1] : 'x) !== 8'd3) begin failures++; $display("FAIL two_awlen1 got=%0d exp=3", aw_len_q.size() > 1 ? aw_len_q[1] : 'x); end
    checks++; if ((aw_size_q.size() > 0 ? aw_size_q[0] : 'x) !== 3'b010) begin failures++; $display("FAIL two_awsize got=%b exp=010", aw_size_q.size() > 0 ? aw_size_q[0] : 'x); end
    checks++; if ((aw_burst_q.size() > 0 ? aw_burst_q[0] : 'x) !== 2'b01) begin failures++; $display("FAIL two_awburst got=%b exp=01", aw_burst_q.size() > 0 ? aw_burst_q[0] : 'x); end
    checks++; if (w_data_q.size() !== 20) begin failures++; $display("FAIL two_beat_count got=%0d exp=20", w_data_q.size()); end
    checks++; if (data_errs(20) !== 0) begin failures++; $display("FAIL two_data got=%0d_bad exp=0_bad", data_errs(20)); end
    checks++; if (last_errs(20, 16) !== 0) begin failures++; $display("FAIL two_wlast got=%0d_bad exp=0_bad", last_errs(20, 16)); end
    checks++; if (se !== 0) begin failures++; $display("FAIL two_wstrb got=%0d_bad exp=0_bad", se); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL two_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_full_frame();
    bit ok;
    int ae;
    mon_clear();
    launch(32'h8000_0000, 32'd1152);
    wait_done(8000, ok);
    ae = 0;
    foreach (aw_addr_q[k])
      if (aw_addr_q[k] !== 32'h8000_0000 + 32'(k) * 32'd64 || aw_len_q[k] !== 8'd15) ae++;
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout got=0 exp=1"); end
    checks++; if (aw_addr_q.size() !== 72) begin failures++; $display("FAIL full_aw_count got=%0d exp=72", aw_addr_q.size()); end
    checks++; if (ae !== 0) begin failures++; $display("FAIL full_aw_fields got=%0d_bad exp=0_bad", ae); end
    checks++; if (w_data_q.size() !== 1152) begin failures++; $display("FAIL full_beat_count got=%0d exp=1152", w_data_q.size()); end
    checks++; if (data_errs(1152) !== 0) begin failures++; $display("FAIL full_data got=%0d_bad exp=0_bad", data_errs(1152)); end
    checks++; if (last_errs(1152, 16) !== 0) begin failures++; $display("FAIL full_wlast got=%0d_bad exp=0_bad", last_errs(1152, 16)); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL full_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_random_stall();
    bit ok;
    mon_clear();
    rand_mode = 1;
    launch(32'h1234_5678, 32'd100);
    wait_done(20000, ok);
    rand_mode = 0;
    checks++; if (!ok) begin failures++; $display("FAIL rand_timeout got=0 exp=1"); end
    checks++; if (w_data_q.size() !== 100) begin failures++; $display("FAIL rand_beat_count got=%0d exp=100", w_data_q.size()); end
    checks++; if (data_errs(100) !== 0) begin failures++; $display("FAIL rand_data got=%0d_bad exp=0_bad", data_errs(100)); end
    checks++; if (aw_addr_q.size() !== 7) begin failures++; $display("FAIL rand_aw_count got=%0d exp=7", aw_addr_q.size()); end
    checks++; if ((aw_addr_q.size() > 6 ? aw_addr_q[6] : 'x) !== 32'h1234_57C0) begin failures++; $display("FAIL rand_awaddr6 got=%h exp=123457c0", aw_addr_q.size() > 6 ? aw_addr_q[6] : 'x); end
    checks++; if ((aw_len_q.size() > 6 ? aw_len_q[6] : 'x) !== 8'd3) begin failures++; $display("FAIL rand_awlen6 got=%0d exp=3", aw_len_q.size() > 6 ? aw_len_q[6] : 'x); end
    checks++; if (last_errs(100, 16) !== 0) begin failures++; $display("FAIL rand_wlast got=%0d_bad exp=0_bad", last_errs(100, 16)); end
  endtask

  task automatic test_bad_resp();
    bit ok;
    mon_clear();
    err_burst = 2;
    launch(32'h0004_0000, 32'd48);
    wait_done(2000, ok);
    err_burst = 0;
    checks++; if (!ok) begin failures++; $display("FAIL err_timeout got=0 exp=1"); end
    checks++; if (b_cnt !== 3) begin failures++; $display("FAIL err_b_count got=%0d exp=3", b_cnt); end
    checks++; if (err_at_done !== 1'b1) begin failures++; $display("FAIL err_at_done got=%b exp=1", err_at_done); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
    mon_clear();
    launch(32'h0004_0000, 32'd4);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear_on_start got=%b exp=0", err); end
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL err2_timeout got=0 exp=1"); end
    checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL err2_at_done got=%b exp=0", err_at_done); end
  endtask

  task automatic test_reset_mid();
    bit ok, mid;
    mon_clear();
    launch(32'h0008_0000, 32'd64);
    mid = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (w_data_q.size() >= 20) begin mid = 1; break; end
    end
    checks++; if (!mid) begin failures++; $display("FAIL mid_reach_timeout got=0 exp=1"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL mid_rst_idle got=%b exp=1", idle); end
    checks++; if (axi.wvalid !== 1'b0 || axi.awvalid !== 1'b0 || axi.bready !== 1'b0) begin failures++; $display("FAIL mid_rst_axi got=%b%b%b exp=000", axi.awvalid, axi.wvalid, axi.bready); end
    checks++; if (ofm_addr !== 13'd0) begin failures++; $display("FAIL mid_rst_ofm_addr got=%0d exp=0", ofm_addr); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_clear();
    launch(32'h0000_0000, 32'd20);
    wait_done(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_rerun_timeout got=0 exp=1"); end
    checks++; if (w_data_q.size() !== 20) begin failures++; $display("FAIL mid_rerun_count got=%0d exp=20", w_data_q.size()); end
    checks++; if ((w_data_q.size() > 0 ? w_data_q[0] : 'x) !== exp_word(0)) begin failures++; $display("FAIL mid_rerun_word0 got=%h exp=%h", w_data_q.size() > 0 ? w_data_q[0] : 'x, exp_word(0)); end
    checks++; if (data_errs(20) !== 0) begin failures++; $display("FAIL mid_rerun_data got=%0d_bad exp=0_bad", data_errs(20)); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL mid_rerun_done got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_two_bursts();
    test_full_frame();
    test_random_stall();
    test_bad_resp();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xcel_ofm_writeback.md
XCEL_OFM_WRITEBACK -- requirements
Module: xcel_ofm_writeback

Interface
REQ-001 The block SHALL have parameter OFM_AWIDTH, default 13: OFM BRAM word-address width.
REQ-002 The block SHALL have parameter BURST_LEN, default 16: maximum beats per AXI write burst, a power of two from 1 to 256.
REQ-003 The block SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-004 The block SHALL have ports: start  in  1  launch pulse; idle  out  1  ready for start; done  out  1  completion pulse; err  out  1  sticky bad-response flag.
REQ-005 The block SHALL have ports: ofm_ddr_addr  in  32  destination byte address; ofm_len  in  32  word count.
REQ-006 The block SHALL have ports: ofm_addr  out  OFM_AWIDTH  BRAM read word address; ofm_dout  in  32  BRAM read data, valid one cycle after ofm_addr (enable tied high).
REQ-007 The block SHALL have AXI4 write-address ports: awvalid out 1, awready in 1, awaddr out 32, awlen out 8, awsize out 3, awburst out 2.
REQ-008 The block SHALL have AXI4 write-data ports: wvalid out 1, wready in 1, wdata out 32, wstrb out 4, wlast out 1.
REQ-009 The block SHALL have AXI4 write-response ports: bvalid in 1, bready out 1, bresp in 2.

Function
REQ-010 The FSM SHALL use states IDLE, AW, W, B, DONE; idle SHALL be 1 only in IDLE.
REQ-011 In IDLE, start=1 SHALL latch ofm_ddr_addr (bits [5:0] forced to 0) and ofm_len, clear err, and move to AW; start outside IDLE SHALL be ignored.
REQ-012 With latched ofm_len=0, the FSM SHALL go IDLE->DONE with no AXI traffic.
REQ-013 Each burst SHALL carry beats=min(BURST_LEN, remaining words), with awlen=beats-1, awaddr=base+4*words_issued, awsize=3'b010, awburst=2'b01, and wstrb=4'hF.
REQ-014 AW SHALL hold awvalid=1 with stable fields until awready=1, then go to W.
REQ-015 W SHALL present wdata from the prefetch FIFO with wvalid=FIFO non-empty; a beat transfers on wvalid&wready; wlast SHALL be 1 on the final beat of the burst; after that beat transfers, the FSM SHALL go to B.
REQ-016 B SHALL assert bready=1; on bvalid the FSM SHALL go to AW if words remain, else DONE; bresp!=2'b00 SHALL set err.
REQ-017 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-018 The prefetch SHALL issue BRAM reads at sequential addresses 0..ofm_len-1 whenever FIFO occupancy plus in-flight reads is less than the FIFO depth, and SHALL write ofm_dout into the FIFO one cycle after each read; prefetch may run ahead across burst boundaries.
REQ-019 No word SHALL be dropped or duplicated under any wready/awready/bvalid stall pattern; output order SHALL equal BRAM address order.
REQ-020 Counters SHALL be 32-bit; ofm_addr SHALL be the low OFM_AWIDTH bits of the read counter.

Reset
REQ-021 rst=1 SHALL force IDLE, empty the FIFO, zero all counters, and drive awvalid=wvalid=bready=done=err=0, idle=1, ofm_addr=0 on the next edge; a reset mid-burst SHALL abandon the transfer (system-wide reset only).

Configuration
REQ-022 With XCEL_WB_RELU_EN defined, wdata SHALL be 0 whenever the FIFO word bit 31 is 1, otherwise the word unchanged; without the macro, wdata SHALL be the FIFO word unchanged.

Structure
REQ-023 Package xcel_pkg SHALL hold the FSM state typedef and the AXI constants (AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00).
REQ-024 The prefetch buffer SHALL be sub-module xcel_wb_fifo: 32-bit, depth 4, synchronous, with full and empty flags.

Verification
REQ-025 ofm_len=1152, wready/awready/bvalid always 1 -> 72 bursts of 16 beats, awaddr stepping by 64, data equals the BRAM image, then done for one cycle.
REQ-026 ofm_len=20 -> two bursts with awlen=15 then awlen=3, wlast on beats 16 and 20.
REQ-027 ofm_len=0 -> done 2 cycles after start, no awvalid.
REQ-028 Random wready (50%) and awready/bvalid delays of 0-7 cycles -> captured stream identical to the BRAM image.
REQ-029 bresp=2'b10 on burst 2 -> err=1 at done; the next start clears err.
REQ-030 Assert rst mid-burst, then start again -> clean second run; with XCEL_WB_RELU_EN, word 0xFFFFFF80 is written as 0.
